// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - counts spikes over a programmable window and presents the rate on a valid/ready register
module spike_rate_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             spike_in,
  input  logic [7:0]       window_len,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_sat,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [8:0]       len_q, len_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] rate_out_q, rate_out_d;
  logic             rate_sat_q, rate_sat_d;
  logic             rate_valid_q, rate_valid_d;
  logic             overrun_q, overrun_d;

  logic [8:0]       fresh_len;
  logic [8:0]       win_len;
  logic [7:0]       cur_cnt;
  logic [CNT_W-1:0] cur_acc;
  logic             cur_sat;
  logic [CNT_W-1:0] next_acc;
  logic             next_sat;
  logic             win_end;

  // Window bookkeeping: an edge taken from IDLE is window cycle 0, so the
  // window state is viewed as freshly cleared and window_len is used directly.
  always_comb begin
    fresh_len    = (window_len == 8'd0) ? 9'd256 : {1'b0, window_len};
    win_len      = (state_q == IDLE) ? fresh_len : len_q;
    cur_cnt      = (state_q == IDLE) ? 8'd0 : cnt_q;
    cur_acc      = (state_q == IDLE) ? '0 : acc_q;
    cur_sat      = (state_q == IDLE) ? 1'b0 : sat_q;
    next_acc     = cur_acc;
    next_sat     = cur_sat;
    win_end      = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    acc_d        = acc_q;
    sat_d        = sat_q;
    rate_out_d   = rate_out_q;
    rate_sat_d   = rate_sat_q;
    rate_valid_d = rate_valid_q;
    overrun_d    = overrun_q;

    if (en) begin
      state_d = COUNT;
      if (spike_in) begin
        if (cur_acc == ACC_MAX) begin
          next_sat = 1'b1;
        end else begin
          next_acc = cur_acc + 1'b1;
        end
      end
      win_end = ({1'b0, cur_cnt} == (win_len - 9'd1));
      if (win_end) begin
        // Publish the finished count and start the next window on the same edge.
        rate_out_d   = next_acc;
        rate_sat_d   = next_sat;
        rate_valid_d = 1'b1;
        if (rate_valid_q && !rate_ready) begin
          overrun_d = 1'b1;
        end
        acc_d = '0;
        sat_d = 1'b0;
        cnt_d = 8'd0;
        len_d = fresh_len;
      end else begin
        acc_d = next_acc;
        sat_d = next_sat;
        cnt_d = cur_cnt + 8'd1;
        len_d = win_len;
      end
    end else begin
      // Enable dropped: abandon any partial window, keep the published result.
      state_d = IDLE;
      acc_d   = '0;
      sat_d   = 1'b0;
      cnt_d   = 8'd0;
    end

    if (!win_end && rate_valid_q && rate_ready) begin
      rate_valid_d = 1'b0;
    end
  end

  // State and result registers; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      len_q        <= 9'd0;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      rate_out_q   <= '0;
      rate_sat_q   <= 1'b0;
      rate_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      acc_q        <= acc_d;
      sat_q        <= sat_d;
      rate_out_q   <= rate_out_d;
      rate_sat_q   <= rate_sat_d;
      rate_valid_q <= rate_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rate_out   = rate_out_q;
  assign rate_sat   = rate_sat_q;
  assign rate_valid = rate_valid_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q == COUNT);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - randomized and directed bench for spike_rate_decoder against a window-level model
module tb_spike_rate_decoder;

  localparam int MAXC = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       spike_in;
  logic [7:0] window_len;
  logic [7:0] rate_out;
  logic       rate_sat;
  logic       rate_valid;
  logic       rate_ready;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a window is a list of sampled cycles of known length.
  bit m_in_win;
  int m_pos;
  int m_len;
  int m_cnt;
  int m_out;
  bit m_sat;
  bit m_valid;
  bit m_ovr;

  spike_rate_decoder #(.CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .spike_in   (spike_in),
    .window_len (window_len),
    .rate_out   (rate_out),
    .rate_sat   (rate_sat),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input bit s, input int w, input bit rd);
    bit fire;
    int res;
    fire = 0;
    res  = 0;
    if (r) begin
      m_in_win = 0; m_pos = 0; m_cnt = 0; m_len = 0;
      m_out = 0; m_sat = 0; m_valid = 0; m_ovr = 0;
      return;
    end
    if (e) begin
      if (!m_in_win) begin
        m_in_win = 1; m_pos = 0; m_cnt = 0;
        m_len = (w == 0) ? 256 : w;
      end
      m_cnt += s;
      if (m_pos == m_len - 1) begin
        fire = 1; res = m_cnt;
        m_pos = 0; m_cnt = 0;
        m_len = (w == 0) ? 256 : w;
      end else begin
        m_pos++;
      end
    end else begin
      m_in_win = 0;
    end
    if (fire) begin
      if (m_valid && !rd) m_ovr = 1;
      m_valid = 1;
      m_out   = (res > MAXC) ? MAXC : res;
      m_sat   = (res > MAXC);
    end else if (m_valid && rd) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit s, input logic [7:0] w, input bit rd);
    @(negedge clk);
    reset = r; en = e; spike_in = s; window_len = w; rate_ready = rd;
    @(posedge clk);
    model_edge(r, e, s, int'(w), rd);
    #1;
    check("rate_out",   rate_out,   m_out);
    check("rate_sat",   rate_sat,   m_sat);
    check("rate_valid", rate_valid, m_valid);
    check("overrun",    overrun,    m_ovr);
    check("busy",       busy,       m_in_win);
  endtask

  initial begin
    reset = 1; en = 0; spike_in = 0; window_len = 0; rate_ready = 0;
    step(1, 0, 0, 8'd0, 0);
    step(1, 0, 0, 8'd0, 0);
    check("reset_out", rate_out, 0);
    check("reset_valid", rate_valid, 0);

    // Basic window: spikes on cycles 0, 3, 9 of a 10-cycle window.
    for (int i = 0; i < 10; i++) step(0, 1, (i == 0 || i == 3 || i == 9), 8'd10, 1);
    check("basic_valid", rate_valid, 1);
    check("basic_out", rate_out, 3);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'd10, 1);
    check("basic_empty_out", rate_out, 0);
    step(0, 1, 0, 8'd10, 1);
    check("basic_valid_pulse", rate_valid, 0);

    // Saturation: 256-cycle window of spikes, then a 255-cycle window.
    step(1, 0, 0, 8'd0, 0);
    for (int i = 0; i < 256; i++) step(0, 1, 1, (i == 255) ? 8'd255 : 8'd0, 1);
    check("sat256_out", rate_out, 255);
    check("sat256_sat", rate_sat, 1);
    for (int i = 0; i < 255; i++) step(0, 1, 1, 8'd255, 1);
    check("sat255_out", rate_out, 255);
    check("sat255_sat", rate_sat, 0);

    // Backpressure: ready low, counts 2 then 1.
    step(1, 0, 0, 8'd0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, (i < 2), 8'd4, 0);
    check("bp_first", rate_out, 2);
    check("bp_no_ovr", overrun, 0);
    for (int i = 0; i < 4; i++) step(0, 1, (i == 0), 8'd4, 0);
    check("bp_second", rate_out, 1);
    check("bp_ovr", overrun, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd4, 1);
    check("bp_ovr_sticky", overrun, 1);

    // Ready pulsed exactly on the second window-end edge.
    step(1, 0, 0, 8'd0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, (i == 0), 8'd4, 0);
    for (int i = 0; i < 4; i++) step(0, 1, (i < 3), 8'd4, (i == 3));
    check("simul_valid", rate_valid, 1);
    check("simul_out", rate_out, 3);
    check("simul_ovr", overrun, 0);

    // Enable drop after 5 spikes in an 8-cycle window.
    step(1, 0, 0, 8'd0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 8'd8, 1);
    step(0, 0, 0, 8'd8, 1);
    check("drop_busy", busy, 0);
    check("drop_valid", rate_valid, 0);
    for (int i = 0; i < 8; i++) step(0, 1, (i == 2 || i == 6), 8'd8, 1);
    check("drop_new_out", rate_out, 2);

    // Reset on a window-end edge while valid and overrun are set.
    step(1, 0, 0, 8'd0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 8'd4, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 8'd4, 0);
    check("pre_reset_ovr", overrun, 1);
    step(1, 1, 1, 8'd4, 1);
    check("rst_out", rate_out, 0);
    check("rst_valid", rate_valid, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      int sel;
      logic [7:0] w;
      sel = $urandom_range(0, 15);
      w = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom_range(1, 6));
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) != 0),
           1'($urandom_range(0, 1)), w, ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
